// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multi-cycle RV32I sequencing controller with memory stall watchdog
// Optional trap on unknown opcodes: define MC_ILLEGAL_TRAP_EN.
module multicycle_ctrl_fsm #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ImmSrc,
   output logic       fault,
   output logic       illegal
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_FAULT
`ifdef MC_ILLEGAL_TRAP_EN
      , S_ILLEGAL
`endif
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             mr;

   // mem_ready is masked while reset is held so no write strobe can leak out
   assign mr = mem_ready & rst;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_FETCH;
         cnt   <= '0;
         fault <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
         illegal <= 1'b0;
`endif
      end else begin
         case (state)
            S_FETCH, S_MEMRD, S_MEMWR: begin
               if (mem_ready) begin
                  cnt <= '0;
                  if (state == S_FETCH)      state <= S_DECODE;
                  else if (state == S_MEMRD) state <= S_MEMWB;
                  else                       state <= S_FETCH;
               end else if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= S_FAULT;
                  fault <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DECODE: begin
               case (opcode)
                  OP_LW, OP_SW: state <= S_MEMADR;
                  OP_R:         state <= S_EXECR;
                  OP_I:         state <= S_EXECI;
                  OP_JAL:       state <= S_JAL;
                  OP_BEQ:       state <= S_BEQ;
                  default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                     state   <= S_ILLEGAL;
                     illegal <= 1'b1;
`else
                     state <= S_FETCH;
`endif
                  end
               endcase
            end
            S_MEMADR: state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMWB:  state <= S_FETCH;
            S_EXECR:  state <= S_ALUWB;
            S_EXECI:  state <= S_ALUWB;
            S_ALUWB:  state <= S_FETCH;
            S_JAL:    state <= S_ALUWB;
            S_BEQ:    state <= S_FETCH;
            S_FAULT:  state <= S_FAULT;
`ifdef MC_ILLEGAL_TRAP_EN
            S_ILLEGAL: state <= S_ILLEGAL;
`endif
            default:  state <= S_FETCH;
         endcase
      end
   end

`ifndef MC_ILLEGAL_TRAP_EN
   assign illegal = 1'b0;
`endif

   always_comb begin
      mem_req   = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      case (state)
         S_FETCH: begin
            mem_req   = 1'b1;
            IRWrite   = mr;
            PCWrite   = mr;
            ResultSrc = 2'b10;
            ALUSrcB   = 2'b10;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            AdrSrc   = 1'b1;
            MemWrite = mr;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
         end
         S_ALUWB: RegWrite = 1'b1;
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            PCWrite = zero;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (opcode)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - randomized bench for multicycle_ctrl_fsm against an instruction-level model
module tb_multicycle_ctrl_fsm;
   localparam int TIMEOUT = 16;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   logic       clk = 1'b0;
   logic       rst, zero, mem_ready;
   logic [6:0] opcode;
   logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, fault, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
   logic [17:0] obs;

   int n_tests = 0;
   int n_fail  = 0;

   logic        q_mr[$];
   logic        q_z[$];
   logic [6:0]  q_op[$];
   logic [17:0] q_exp[$];

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
      .fault(fault), .illegal(illegal)
   );

   assign obs = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, fault, illegal};

   function automatic logic [17:0] v(input logic req, adr, irw, pcw, mw, rw,
                                     input logic [1:0] rs, sa, sb, aop, imm);
      return {req, adr, irw, pcw, mw, rw, rs, sa, sb, aop, imm, 2'b00};
   endfunction

   function automatic logic [1:0] imm_of(input logic [6:0] op);
      case (op)
         OP_SW:   return 2'b01;
         OP_BEQ:  return 2'b10;
         OP_JAL:  return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic void push(input logic [6:0] op, input logic mr, z, input logic [17:0] e);
      q_op.push_back(op);
      q_mr.push_back(mr);
      q_z.push_back(z);
      q_exp.push_back(e);
   endfunction

   // One instruction expanded into its per-cycle expected control word; sf/sm are stall cycles
   function automatic void model_instr(input logic [6:0] op, input int sf, sm, input logic bz);
      logic [1:0] im;
      im = imm_of(op);
      for (int i = 0; i < sf; i++) push(op, 1'b0, rnd(), v(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, im));
      push(op, 1'b1, rnd(), v(1,0,1,1,0,0, 2'b10,2'b00,2'b10,2'b00, im));
      push(op, rnd(), rnd(), v(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, im));
      case (op)
         OP_LW, OP_SW: begin
            push(op, rnd(), rnd(), v(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, im));
            for (int i = 0; i < sm; i++) push(op, 1'b0, rnd(), v(1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, im));
            if (op == OP_LW) begin
               push(op, 1'b1, rnd(), v(1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, im));
               push(op, rnd(), rnd(), v(0,0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, im));
            end else begin
               push(op, 1'b1, rnd(), v(1,1,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, im));
            end
         end
         OP_R, OP_I: begin
            push(op, rnd(), rnd(), v(0,0,0,0,0,0, 2'b00,2'b10,(op == OP_I) ? 2'b01 : 2'b00,2'b10, im));
            push(op, rnd(), rnd(), v(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, im));
         end
         OP_JAL: begin
            push(op, rnd(), rnd(), v(0,0,0,1,0,0, 2'b00,2'b01,2'b10,2'b00, im));
            push(op, rnd(), rnd(), v(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, im));
         end
         OP_BEQ: push(op, rnd(), bz, v(0,0,0,bz,0,0, 2'b00,2'b10,2'b00,2'b01, im));
         default: ;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; opcode = OP_R; mem_ready = 1'b1; zero = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_tests++;
         if (obs !== v(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 2'b00)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs, v(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 2'b00));
         end
         tick();
      end
      rst = 1'b1;
   endtask

   task automatic test_directed();
      int c;
      logic [17:0] e;
      model_instr(OP_R, 0, 0, 1'b0);
      model_instr(OP_LW, 0, 3, 1'b0);
      model_instr(OP_BEQ, 0, 0, 1'b1);
      model_instr(OP_BEQ, 0, 0, 1'b0);
      model_instr(OP_SW, 1, 2, 1'b0);
      model_instr(OP_JAL, 0, 0, 1'b0);
      model_instr(OP_I, 2, 0, 1'b0);
      model_instr(OP_R, TIMEOUT - 1, 0, 1'b0);
      model_instr(OP_LW, 0, TIMEOUT - 1, 1'b0);
`ifndef MC_ILLEGAL_TRAP_EN
      model_instr(7'b1111111, 0, 0, 1'b0);
`endif
      c = 0;
      while (q_exp.size() > 0) begin
         opcode = q_op.pop_front(); mem_ready = q_mr.pop_front(); zero = q_z.pop_front();
         e = q_exp.pop_front();
         @(negedge clk);
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL directed cycle %0d op=%b: got %h want %h", c, opcode, obs, e);
         end
         c++;
         tick();
      end
   endtask

   task automatic test_random();
      logic [6:0] ops[8];
      int c, nops;
      logic [17:0] e;
      ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ, 7'b0110111, 7'b1111111};
`ifdef MC_ILLEGAL_TRAP_EN
      nops = 6;
`else
      nops = 8;
`endif
      for (int k = 0; k < 40; k++)
         model_instr(ops[$urandom_range(0, nops - 1)], $urandom_range(0, 3), $urandom_range(0, 3), rnd());
      c = 0;
      while (q_exp.size() > 0) begin
         opcode = q_op.pop_front(); mem_ready = q_mr.pop_front(); zero = q_z.pop_front();
         e = q_exp.pop_front();
         @(negedge clk);
         n_tests++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL random cycle %0d op=%b: got %h want %h", c, opcode, obs, e);
         end
         c++;
         tick();
      end
   endtask

   task automatic test_illegal();
      opcode = 7'b1111111; mem_ready = 1'b1; zero = 1'b0;
      tick();
      mem_ready = 1'b0;
      tick();
`ifdef MC_ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) begin
         mem_ready = rnd();
         @(negedge clk);
         n_tests++;
         if (obs !== 18'b01) begin
            n_fail++;
            $display("FAIL illegal_hang: got %h want %h", obs, 18'b01);
         end
         tick();
      end
`else
      @(negedge clk);
      n_tests++;
      if (obs !== v(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 2'b00)) begin
         n_fail++;
         $display("FAIL illegal_nop_fetch: got %h want %h", obs, v(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 2'b00));
      end
`endif
      rst = 1'b0;
      #1;
      n_tests++;
      if (illegal !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_clear: got %b want 0", illegal);
      end
      tick();
      rst = 1'b1;
   endtask

   task automatic test_timeout();
      opcode = OP_R; mem_ready = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clk);
         n_tests++;
         if (mem_req !== 1'b1 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_wait %0d: got req=%b fault=%b want req=1 fault=0", i, mem_req, fault);
         end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         mem_ready = rnd();
         @(negedge clk);
         n_tests++;
         if (obs !== 18'b10) begin
            n_fail++;
            $display("FAIL fault_hold %0d: got %h want %h", i, obs, 18'b10);
         end
         tick();
      end
      rst = 1'b0;
      #2;
      n_tests++;
      if (fault !== 1'b0 || mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL fault_clear: got fault=%b req=%b want fault=0 req=1", fault, mem_req);
      end
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset_mid_memwr();
      opcode = OP_SW; mem_ready = 1'b1;
      tick();
      tick();
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      n_tests++;
      if (mem_req !== 1'b1 || AdrSrc !== 1'b1 || MemWrite !== 1'b0) begin
         n_fail++;
         $display("FAIL memwr_wait: got req=%b adr=%b mw=%b want 1 1 0", mem_req, AdrSrc, MemWrite);
      end
      mem_ready = 1'b1;
      rst = 1'b0;
      #1;
      n_tests++;
      if (obs !== v(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 2'b01)) begin
         n_fail++;
         $display("FAIL reset_mid_memwr: got %h want %h", obs, v(1,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 2'b01));
      end
      tick();
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_fetch: got irw=%b pcw=%b want 1 1", IRWrite, PCWrite);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_illegal();
      test_timeout();
      test_reset_mid_memwr();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
